// File: rtl/pillar_mem_pkg.sv
// pillar_mem_pkg: shared encodings for the memory bridge and its lane aligner
package pillar_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int MB_TO_W = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE, ST_ERR} mb_state_t;
  function automatic logic mb_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'b11) || (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store lane replication and load lane extraction/extension
module mem_lane_align
  import pillar_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [15:0] w_shift;
  always_comb begin
    w_shift = 16'(rdata_i >> {off_i, 3'b000});
    be_o    = size_i == SZ_BYTE ? 4'b0001 << off_i :
              size_i == SZ_HALF ? 4'b0011 << off_i :
              size_i == SZ_WORD ? 4'b1111 : 4'b0000;
    wdata_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
              size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o = size_i == SZ_BYTE ? {{24{sext_i & w_shift[7]}}, w_shift[7:0]} :
              size_i == SZ_HALF ? {{16{sext_i & w_shift[15]}}, w_shift[15:0]} : rdata_i;
  end
endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: one-at-a-time load/store bridge from the memory stage to a handshaked bus
module mem_bridge
  import pillar_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        stall_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);
  mb_state_t          r_state, w_next;
  logic               r_we, r_sext, w_timeout;
  logic [1:0]         r_size;
  logic [31:0]        r_addr, r_wdata, r_rdata, w_wdata, w_rdata;
  logic [3:0]         w_be;
  logic [MB_TO_W-1:0] r_cnt;
  mem_lane_align u_align (
    .size_i  (r_size),
    .off_i   (r_addr[1:0]),
    .sext_i  (r_sext),
    .wdata_i (r_wdata),
    .rdata_i (bus_rdata_i),
    .be_o    (w_be),
    .wdata_o (w_wdata),
    .rdata_o (w_rdata)
  );
  always_comb begin
    w_next      = r_state;
    w_timeout   = r_cnt == MB_TO_W'(TIMEOUT - 1);
    unique case (r_state)
      ST_IDLE: if (req_i) w_next = mb_bad_access(size_i, addr_i[1:0]) ? ST_ERR : ST_ADDR;
      ST_ADDR: w_next = bus_ready_i ? (r_we ? ST_DONE : ST_DATA) : w_timeout ? ST_ERR : ST_ADDR;
      ST_DATA: w_next = bus_rvalid_i ? ST_DONE : w_timeout ? ST_ERR : ST_DATA;
      default: w_next = ST_IDLE;
    endcase
    bus_valid_o = r_state == ST_ADDR;
    bus_we_o    = bus_valid_o & r_we;
    bus_addr_o  = bus_valid_o ? {r_addr[31:2], 2'b00} : '0;
    bus_be_o    = bus_valid_o ? w_be : '0;
    bus_wdata_o = bus_valid_o ? w_wdata : '0;
    done_o      = r_state == ST_DONE;
    err_o       = r_state == ST_ERR;
    rdata_o     = err_o ? '0 : r_rdata;
    stall_o     = bus_valid_o | (r_state == ST_DATA) | (r_state == ST_IDLE & req_i);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_sext  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      // counts only while waiting in the same bus phase; any phase change restarts it
      r_cnt   <= (w_next == r_state && (r_state == ST_ADDR || r_state == ST_DATA)) ? r_cnt + 1'b1 : '0;
      if (r_state == ST_IDLE && req_i) {r_we, r_size, r_sext, r_addr, r_wdata} <= {we_i, size_i, sext_i, addr_i, wdata_i};
      if (r_state == ST_DATA && bus_rvalid_i) r_rdata <= w_rdata;
    end
  end
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed and randomized checks of mem_bridge against a lane-level model
module tb_mem_bridge;
  logic clk = 0, reset = 0, req_i = 0, we_i = 0, sext_i = 0, bus_ready_i = 0, bus_rvalid_i = 0;
  logic [1:0] size_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, bus_rdata_i = 0;
  logic [31:0] a_rdata, b_rdata, a_addr, b_addr, a_wdata, b_wdata;
  logic [3:0] a_be, b_be;
  logic a_done, b_done, a_err, b_err, a_stall, b_stall, a_valid, b_valid, a_we, b_we;
  logic [127:0] got_v, exp_v;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_bridge #(.TIMEOUT(4)) u_a (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .size_i(size_i), .sext_i(sext_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(a_rdata), .done_o(a_done), .err_o(a_err),
    .stall_o(a_stall), .bus_valid_o(a_valid), .bus_ready_i(bus_ready_i), .bus_we_o(a_we),
    .bus_addr_o(a_addr), .bus_be_o(a_be), .bus_wdata_o(a_wdata), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i)
  );
  mem_bridge u_b (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .size_i(size_i), .sext_i(sext_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(b_rdata), .done_o(b_done), .err_o(b_err),
    .stall_o(b_stall), .bus_valid_o(b_valid), .bus_ready_i(bus_ready_i), .bus_we_o(b_we),
    .bus_addr_o(b_addr), .bus_be_o(b_be), .bus_wdata_o(b_wdata), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i)
  );
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
    int n = 1 << sz;
    return 4'(((1 << n) - 1) << off);
  endfunction
  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n = 1 << sz;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] m_rd(input logic [1:0] sz, input logic sx, input logic [1:0] off, input logic [31:0] rd);
    int n = 1 << sz;
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    logic [31:0] v = (rd >> (8 * int'(off))) & mask;
    if (sx && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction
  task automatic do_reset;
    @(negedge clk);
    reset = 0; req_i = 0; bus_ready_i = 0; bus_rvalid_i = 0;
    @(negedge clk);
    reset = 1;
  endtask
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic sx, input logic [31:0] ad,
                         input logic [31:0] wd, input int dr, input int dv, input logic [31:0] rd);
    logic [3:0] ebe = m_be(sz, ad[1:0]);
    logic [31:0] ewd = m_wd(sz, wd);
    logic [31:0] erd = m_rd(sz, sx, ad[1:0], rd);
    @(negedge clk);
    req_i = 1; we_i = we; size_i = sz; sext_i = sx; addr_i = ad; wdata_i = wd; #1;
    total++;
    if ({b_stall, b_valid, b_done, b_err} !== 4'b1000) begin
      bad++; $display("FAIL txn_req got=%b exp=1000", {b_stall, b_valid, b_done, b_err});
    end
    for (int c = 0; c <= dr; c++) begin
      @(negedge clk);
      req_i = 0; we_i = 1'($urandom); size_i = 2'($urandom); addr_i = $urandom; wdata_i = $urandom;
      bus_ready_i = (c == dr); #1;
      got_v = 128'({b_valid, b_we, b_stall, b_done, b_err, b_be, b_addr, we ? b_wdata : 32'd0});
      exp_v = 128'({1'b1, we, 3'b100, ebe, ad[31:2], 2'b00, we ? ewd : 32'd0});
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL txn_addr got=%h exp=%h", got_v, exp_v); end
    end
    if (!we) for (int c = 0; c <= dv; c++) begin
      @(negedge clk);
      bus_ready_i = 0; bus_rvalid_i = (c == dv); bus_rdata_i = (c == dv) ? rd : $urandom; #1;
      total++;
      if ({b_valid, b_stall, b_done, b_err} !== 4'b0100) begin
        bad++; $display("FAIL txn_data got=%b exp=0100", {b_valid, b_stall, b_done, b_err});
      end
    end
    @(negedge clk);
    bus_ready_i = 0; bus_rvalid_i = 0; bus_rdata_i = $urandom; #1;
    got_v = 128'({b_done, b_err, b_valid, we ? 32'd0 : b_rdata});
    exp_v = 128'({3'b100, we ? 32'd0 : erd});
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL txn_done got=%h exp=%h", got_v, exp_v); end
  endtask
  task automatic test_reset;
    @(negedge clk);
    reset = 0; req_i = 0; #1;
    got_v = 128'({a_rdata, a_done, a_err, a_stall, a_valid, a_we, a_addr, a_be, a_wdata});
    total++;
    if (got_v !== 128'd0) begin bad++; $display("FAIL reset_a got=%h exp=0", got_v); end
    got_v = 128'({b_rdata, b_done, b_err, b_stall, b_valid, b_we, b_addr, b_be, b_wdata});
    total++;
    if (got_v !== 128'd0) begin bad++; $display("FAIL reset_b got=%h exp=0", got_v); end
    reset = 1;
  endtask
  task automatic test_word_store;
    do_reset;
    @(negedge clk);
    req_i = 1; we_i = 1; size_i = 2'b10; addr_i = 32'h100; wdata_i = 32'hDEADBEEF; #1;
    total++;
    if ({b_stall, b_valid, b_done} !== 3'b100) begin bad++; $display("FAIL ws_c0 got=%b exp=100", {b_stall, b_valid, b_done}); end
    @(negedge clk);
    req_i = 0; addr_i = 0; wdata_i = 0; bus_ready_i = 1; #1;
    got_v = 128'({b_stall, b_valid, b_we, b_be, b_addr, b_wdata, b_done});
    exp_v = 128'({3'b111, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0});
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL ws_c1 got=%h exp=%h", got_v, exp_v); end
    @(negedge clk);
    bus_ready_i = 0; #1;
    total++;
    if ({b_stall, b_valid, b_done, b_err} !== 4'b0010) begin bad++; $display("FAIL ws_c2 got=%b exp=0010", {b_stall, b_valid, b_done, b_err}); end
  endtask
  task automatic test_byte_load;
    for (int s = 1; s >= 0; s--) begin
      @(negedge clk);
      req_i = 1; we_i = 0; size_i = 2'b00; sext_i = s[0]; addr_i = 32'h203; #1;
      @(negedge clk);
      req_i = 0; bus_ready_i = 1; #1;
      got_v = 128'({b_valid, b_we, b_be, b_addr});
      exp_v = 128'({2'b10, 4'h8, 32'h200});
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL bl_addr got=%h exp=%h", got_v, exp_v); end
      @(negedge clk);
      bus_ready_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h80FF1234; #1;
      total++;
      if ({b_valid, b_stall, b_done} !== 3'b010) begin bad++; $display("FAIL bl_data got=%b exp=010", {b_valid, b_stall, b_done}); end
      @(negedge clk);
      bus_rvalid_i = 0; #1;
      got_v = 128'({b_done, b_err, b_rdata});
      exp_v = 128'({2'b10, s[0] ? 32'hFFFFFF80 : 32'h00000080});
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL bl_done got=%h exp=%h", got_v, exp_v); end
    end
  endtask
  task automatic test_half;
    @(negedge clk);
    req_i = 1; we_i = 1; size_i = 2'b01; addr_i = 32'h102; wdata_i = 32'h0000ABCD; #1;
    @(negedge clk);
    req_i = 0; bus_ready_i = 1; #1;
    got_v = 128'({b_valid, b_we, b_be, b_addr, b_wdata});
    exp_v = 128'({2'b11, 4'hC, 32'h100, 32'hABCDABCD});
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL hs_addr got=%h exp=%h", got_v, exp_v); end
    @(negedge clk);
    bus_ready_i = 0; #1;
    total++;
    if (b_done !== 1'b1) begin bad++; $display("FAIL hs_done got=%b exp=1", b_done); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_i = 1; we_i = 0; size_i = k == 0 ? 2'b01 : 2'b11; addr_i = k == 0 ? 32'h101 : 32'h104; #1;
      total++;
      if (b_valid !== 1'b0) begin bad++; $display("FAIL err_c0 got=%b exp=0", b_valid); end
      @(negedge clk);
      req_i = 0; #1;
      got_v = 128'({b_err, b_done, b_valid, b_rdata});
      exp_v = 128'({3'b100, 32'd0});
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL err_c1 got=%h exp=%h", got_v, exp_v); end
      @(negedge clk);
      #1;
      got_v = 128'({b_err, b_valid, b_rdata});
      exp_v = 128'({2'b00, 32'h00000080});
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL err_c2 got=%h exp=%h", got_v, exp_v); end
    end
  endtask
  task automatic test_timeout_addr;
    do_reset;
    @(negedge clk);
    req_i = 1; we_i = 0; size_i = 2'b10; addr_i = 32'h40; #1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_i = 0; #1;
      total++;
      if ({a_valid, a_err} !== 2'b10) begin bad++; $display("FAIL toa_wait c=%0d got=%b exp=10", c, {a_valid, a_err}); end
    end
    @(negedge clk);
    #1;
    got_v = 128'({a_valid, a_err, a_done, a_rdata});
    exp_v = 128'({3'b010, 32'd0});
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL toa_err got=%h exp=%h", got_v, exp_v); end
  endtask
  task automatic test_timeout_data;
    do_reset;
    @(negedge clk);
    req_i = 1; we_i = 0; size_i = 2'b10; addr_i = 32'h80; #1;
    @(negedge clk);
    req_i = 0; bus_ready_i = 1; #1;
    total++;
    if (a_valid !== 1'b1) begin bad++; $display("FAIL tod_addr got=%b exp=1", a_valid); end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      bus_ready_i = 0; #1;
      total++;
      if ({a_valid, a_stall, a_err} !== 3'b010) begin bad++; $display("FAIL tod_wait c=%0d got=%b exp=010", c, {a_valid, a_stall, a_err}); end
    end
    @(negedge clk);
    bus_rvalid_i = 1; bus_rdata_i = 32'h12345678; #1;
    total++;
    if ({a_err, a_done} !== 2'b10) begin bad++; $display("FAIL tod_err got=%b exp=10", {a_err, a_done}); end
    for (int c = 7; c <= 8; c++) begin
      @(negedge clk);
      bus_rvalid_i = c == 7; #1;
      got_v = 128'({a_done, a_err, a_rdata});
      total++;
      if (got_v !== 128'd0) begin bad++; $display("FAIL tod_late c=%0d got=%h exp=0", c, got_v); end
    end
  endtask
  task automatic test_reset_mid;
    do_reset;
    @(negedge clk);
    req_i = 1; we_i = 0; size_i = 2'b10; addr_i = 32'h300; #1;
    @(negedge clk);
    req_i = 0; bus_ready_i = 1; #1;
    @(negedge clk);
    bus_ready_i = 0; reset = 0; #1;
    @(negedge clk);
    #1;
    got_v = 128'({a_rdata, a_done, a_err, a_stall, a_valid, a_we, a_addr, a_be, a_wdata});
    total++;
    if (got_v !== 128'd0) begin bad++; $display("FAIL rmid_a got=%h exp=0", got_v); end
    got_v = 128'({b_rdata, b_done, b_err, b_stall, b_valid, b_we, b_addr, b_be, b_wdata});
    total++;
    if (got_v !== 128'd0) begin bad++; $display("FAIL rmid_b got=%h exp=0", got_v); end
    reset = 1;
    run_txn(1'b0, 2'b01, 1'b1, 32'h306, 32'd0, 0, 0, 32'h9ABC5555);
  endtask
  task automatic test_back_to_back;
    do_reset;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_i = 1; we_i = 1; size_i = 2'b10; addr_i = 32'h500; wdata_i = c; bus_ready_i = 1; #1;
      got_v = 128'({b_valid, b_done});
      exp_v = 128'({c % 3 == 1, c % 3 == 2});
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL b2b c=%0d got=%h exp=%h", c, got_v, exp_v); end
    end
    @(negedge clk);
    req_i = 0; bus_ready_i = 0;
  endtask
  task automatic test_sweep;
    logic [1:0] sz;
    logic [31:0] ad;
    do_reset;
    for (int t = 0; t < 200; t++) begin
      sz = 2'($urandom_range(0, 2));
      ad = $urandom;
      if (sz == 2'b01) ad[0] = 1'b0;
      if (sz == 2'b10) ad[1:0] = 2'b00;
      run_txn(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom_range(0, 10), $urandom_range(0, 10), $urandom);
    end
  endtask
  initial begin
    test_reset;
    test_word_store;
    test_byte_load;
    test_half;
    test_timeout_addr;
    test_timeout_data;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
